// File: rtl/spi_flash_responder.sv
// SPI NOR flash responder: 0x03 read, 0x05 status, 0x9F ID, 0x06/0x04 WEL.
// Define SPI_FLASH_RESPONDER_PROGRAM_EN to add a RAM and 0x02 page program.
module spi_flash_responder #(
    parameter logic [23:0] JEDEC_ID  = 24'hEF4018,
    parameter int          ADDR_BITS = 8
) (
    input  logic       CLKA,
    input  logic       rst_n,
    input  logic       MEM_VCC,
    input  logic       SPI_CLK,
    input  logic       SPI_CS_n,
    input  logic       SPI_MOSI,
    output logic       SPI_MISO,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic       wel
);

    localparam int SH_W = (ADDR_BITS > 8) ? ADDR_BITS : 8;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, READ, PROG, STATUS, ID, IGNORE
    } state_t;

    state_t               state;
    logic [1:0]           sclk_s, cs_s, mosi_s;
    logic                 sclk_d, cs_d;
    logic                 sclk_rise, sclk_fall;
    logic                 cs_rise, cs_fall, cs_act;
    logic [4:0]           bit_cnt;
    logic [SH_W-2:0]      shreg;
    logic [SH_W-1:0]      sh_next;
    logic [7:0]           tx;
    logic [1:0]           id_idx;
    logic                 is_prog;
    logic [ADDR_BITS-1:0] ptr, addr_lo;

    always_ff @(posedge CLKA or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s <= 2'b00;
            cs_s   <= 2'b11;
            mosi_s <= 2'b00;
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sclk_s <= {sclk_s[0], SPI_CLK};
            cs_s   <= {cs_s[0], SPI_CS_n};
            mosi_s <= {mosi_s[0], SPI_MOSI};
            sclk_d <= sclk_s[1];
            cs_d   <= cs_s[1];
        end
    end

    assign sclk_rise = sclk_s[1] & ~sclk_d;
    assign sclk_fall = ~sclk_s[1] & sclk_d;
    assign cs_rise   = cs_s[1] & ~cs_d;
    assign cs_fall   = ~cs_s[1] & cs_d;
    assign cs_act    = ~cs_s[1];
    assign sh_next   = {shreg, mosi_s[1]};
    assign addr_lo   = sh_next[ADDR_BITS-1:0];

`ifdef SPI_FLASH_RESPONDER_PROGRAM_EN
    logic [7:0] mem [0:(1<<ADDR_BITS)-1];
    logic       mem_we;

    assign mem_we = MEM_VCC && cs_act && sclk_rise && state == PROG
                    && bit_cnt == 5'd7 && wel;

    // Array contents survive reset, so no reset branch here.
    always_ff @(posedge CLKA) begin
        if (mem_we) mem[ptr] <= sh_next[7:0];
    end

    function automatic logic [7:0] rd_byte(input logic [ADDR_BITS-1:0] p);
        return mem[p];
    endfunction
`else
    function automatic logic [7:0] rd_byte(input logic [ADDR_BITS-1:0] p);
        return 8'(p) ^ 8'hA5;
    endfunction
`endif

    function automatic logic [7:0] id_byte(input logic [1:0] i);
        case (i)
            2'd0:    return JEDEC_ID[23:16];
            2'd1:    return JEDEC_ID[15:8];
            2'd2:    return JEDEC_ID[7:0];
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge CLKA or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            SPI_MISO  <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_code  <= 8'h00;
            wel       <= 1'b0;
            ptr       <= '0;
            bit_cnt   <= 5'd0;
            shreg     <= '0;
            tx        <= 8'h00;
            id_idx    <= 2'd0;
            is_prog   <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            if (!MEM_VCC) begin
                state    <= IDLE;
                wel      <= 1'b0;
                SPI_MISO <= 1'b0;
                cmd_code <= 8'h00;
                bit_cnt  <= 5'd0;
            end else if (cs_rise) begin
                if (state == PROG) wel <= 1'b0;
                state    <= IDLE;
                SPI_MISO <= 1'b0;
                bit_cnt  <= 5'd0;
                shreg    <= '0;
            end else if (cs_fall && state == IDLE) begin
                state   <= CMD;
                bit_cnt <= 5'd0;
            end else if (cs_act && sclk_rise) begin
                bit_cnt <= bit_cnt + 5'd1;
                shreg   <= sh_next[SH_W-2:0];
                unique case (state)
                    CMD: if (bit_cnt == 5'd7) begin
                        bit_cnt   <= 5'd0;
                        cmd_code  <= sh_next[7:0];
                        cmd_valid <= 1'b1;
                        case (sh_next[7:0])
                            8'h03: begin
                                state   <= ADDR;
                                is_prog <= 1'b0;
                            end
`ifdef SPI_FLASH_RESPONDER_PROGRAM_EN
                            8'h02: begin
                                state   <= ADDR;
                                is_prog <= 1'b1;
                            end
`endif
                            8'h05: begin
                                state <= STATUS;
                                tx    <= {6'b0, wel, 1'b0};
                            end
                            8'h9F: begin
                                state  <= ID;
                                tx     <= id_byte(2'd0);
                                id_idx <= 2'd1;
                            end
                            8'h06: begin
                                state <= IGNORE;
                                wel   <= 1'b1;
                            end
                            8'h04: begin
                                state <= IGNORE;
                                wel   <= 1'b0;
                            end
                            default: state <= IGNORE;
                        endcase
                    end
                    ADDR: if (bit_cnt == 5'd23) begin
                        bit_cnt <= 5'd0;
                        if (is_prog) begin
                            state <= PROG;
                            ptr   <= addr_lo;
                        end else begin
                            state <= READ;
                            tx    <= rd_byte(addr_lo);
                            ptr   <= addr_lo + ADDR_BITS'(1);
                        end
                    end
                    READ: if (bit_cnt == 5'd7) begin
                        bit_cnt <= 5'd0;
                        tx      <= rd_byte(ptr);
                        ptr     <= ptr + ADDR_BITS'(1);
                    end
                    PROG: if (bit_cnt == 5'd7) begin
                        bit_cnt <= 5'd0;
                        ptr     <= ptr + ADDR_BITS'(1);
                    end
                    STATUS: if (bit_cnt == 5'd7) begin
                        bit_cnt <= 5'd0;
                        tx      <= {6'b0, wel, 1'b0};
                    end
                    ID: if (bit_cnt == 5'd7) begin
                        bit_cnt <= 5'd0;
                        tx      <= id_byte(id_idx);
                        if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                    end
                    default: bit_cnt <= 5'd0;
                endcase
            end else if (cs_act && sclk_fall) begin
                // Byte is preloaded on the rising edge; falls only shift it out.
                if (state == READ || state == STATUS || state == ID) begin
                    SPI_MISO <= tx[7];
                    tx       <= {tx[6:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed + randomized bench for spi_flash_responder with a byte-level model.
module tb_spi_flash_responder;

    logic       CLKA = 1'b0;
    logic       rst_n, MEM_VCC, SPI_CLK, SPI_CS_n, SPI_MOSI;
    logic       SPI_MISO, cmd_valid, wel;
    logic [7:0] cmd_code;

    spi_flash_responder dut (
        .CLKA(CLKA), .rst_n(rst_n), .MEM_VCC(MEM_VCC),
        .SPI_CLK(SPI_CLK), .SPI_CS_n(SPI_CS_n), .SPI_MOSI(SPI_MOSI),
        .SPI_MISO(SPI_MISO), .cmd_valid(cmd_valid),
        .cmd_code(cmd_code), .wel(wel)
    );

    always #5 CLKA = ~CLKA;

    int passed = 0, failed = 0, total = 0;
    int cv_cnt = 0;
    logic [7:0] cv_last = 8'h00;
    logic [7:0] rx[$];
    logic [7:0] wq[$];
    logic [7:0] model_mem [256];
    bit model_wel = 1'b0;

    always @(negedge CLKA) begin
        if (cmd_valid) begin
            cv_cnt++;
            cv_last = cmd_code;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: no finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input int a);
`ifdef SPI_FLASH_RESPONDER_PROGRAM_EN
        return model_mem[a % 256];
`else
        return 8'(a % 256) ^ 8'hA5;
`endif
    endfunction

    task automatic xfer(input logic [7:0] o, input int nb,
                        output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nb; i++) begin
            SPI_MOSI = o[7-i];
            repeat (6) @(negedge CLKA);
            r[7-i] = SPI_MISO;
            SPI_CLK = 1'b1;
            repeat (6) @(negedge CLKA);
            SPI_CLK = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(negedge CLKA);
        SPI_CS_n = 1'b0;
        repeat (6) @(negedge CLKA);
    endtask

    task automatic cs_high();
        repeat (6) @(negedge CLKA);
        SPI_CS_n = 1'b1;
        repeat (8) @(negedge CLKA);
    endtask

    task automatic put(input logic [7:0] o);
        logic [7:0] d;
        xfer(o, 8, d);
    endtask

    task automatic get_bytes(input int n);
        logic [7:0] d;
        rx.delete();
        for (int k = 0; k < n; k++) begin
            xfer(8'h00, 8, d);
            rx.push_back(d);
        end
    endtask

    task automatic do_cmd(input logic [7:0] c, input int n);
        cs_low();
        put(c);
        get_bytes(n);
        cs_high();
    endtask

    task automatic do_read(input logic [23:0] a, input int n);
        cs_low();
        put(8'h03);
        put(a[23:16]);
        put(a[15:8]);
        put(a[7:0]);
        get_bytes(n);
        cs_high();
    endtask

    task automatic do_prog(input logic [23:0] a);
        cs_low();
        put(8'h02);
        put(a[23:16]);
        put(a[15:8]);
        put(a[7:0]);
        foreach (wq[k]) put(wq[k]);
        cs_high();
    endtask

    initial begin
        int a, n, c0;
        logic [15:0] hi;
        logic [7:0] d, c;
        rst_n = 1'b0;
        MEM_VCC = 1'b1;
        SPI_CLK = 1'b0;
        SPI_CS_n = 1'b1;
        SPI_MOSI = 1'b0;
        repeat (3) @(negedge CLKA);
        check("rst_miso", SPI_MISO, 0);
        check("rst_cmd_code", cmd_code, 8'h00);
        check("rst_wel", wel, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge CLKA);

        c0 = cv_cnt;
        do_cmd(8'h9F, 4);
        check("id0", rx[0], 8'hEF);
        check("id1", rx[1], 8'h40);
        check("id2", rx[2], 8'h18);
        check("id3_pad", rx[3], 8'h00);
        check("id_cv_pulses", cv_cnt - c0, 1);
        check("id_cmd_code", cv_last, 8'h9F);

        do_cmd(8'h05, 1);
        check("st_init", rx[0], 8'h00);
        do_cmd(8'h06, 0);
        model_wel = 1'b1;
        check("wel_set", wel, model_wel);
        do_cmd(8'h05, 2);
        check("st_wel0", rx[0], 8'h02);
        check("st_wel1", rx[1], 8'h02);
        do_cmd(8'h04, 0);
        model_wel = 1'b0;
        check("wel_clr", wel, model_wel);
        do_cmd(8'h05, 1);
        check("st_clr", rx[0], 8'h00);

        // Random WEL history against the status byte.
        for (int t = 0; t < 5; t++) begin
            c = ($urandom_range(0, 1) == 1) ? 8'h06 : 8'h04;
            do_cmd(c, 0);
            model_wel = (c == 8'h06);
            do_cmd(8'h05, 2);
            check("rnd_st0", rx[0], {6'b0, model_wel, 1'b0});
            check("rnd_st1", rx[1], {6'b0, model_wel, 1'b0});
            check("rnd_wel", wel, model_wel);
        end

`ifdef SPI_FLASH_RESPONDER_PROGRAM_EN
        do_cmd(8'h06, 0);
        model_wel = 1'b1;
        wq = '{8'h11, 8'h22};
        do_prog(24'h000010);
        model_mem[16] = 8'h11;
        model_mem[17] = 8'h22;
        model_wel = 1'b0;
        check("prog_wel_clr", wel, model_wel);
        do_read(24'h000010, 2);
        check("prog_rd0", rx[0], 8'h11);
        check("prog_rd1", rx[1], 8'h22);
        for (int t = 0; t < 4; t++) begin
            a = $urandom_range(0, 255);
            n = $urandom_range(1, 5);
            hi = 16'($urandom());
            do_cmd(8'h06, 0);
            wq.delete();
            for (int k = 0; k < n; k++) begin
                d = 8'($urandom());
                wq.push_back(d);
                model_mem[(a + k) % 256] = d;
            end
            do_prog({hi, 8'(a)});
            check("rnd_prog_wel", wel, 0);
            do_read({hi, 8'(a)}, n);
            for (int k = 0; k < n; k++)
                check("rnd_prog_rd", rx[k], model_read(a + k));
        end
        // WEL low: program bytes must be dropped.
        wq.delete();
        for (int k = 0; k < n; k++) wq.push_back(~model_mem[(a + k) % 256]);
        do_prog({hi, 8'(a)});
        do_read({hi, 8'(a)}, n);
        for (int k = 0; k < n; k++)
            check("nowel_rd", rx[k], model_read(a + k));
`else
        do_read(24'h0000FE, 4);
        check("rd_fe", rx[0], 8'h5B);
        check("rd_ff", rx[1], 8'h5A);
        check("rd_wrap0", rx[2], 8'hA5);
        check("rd_wrap1", rx[3], 8'hA4);
        for (int t = 0; t < 4; t++) begin
            a = $urandom_range(0, 255);
            n = $urandom_range(1, 6);
            hi = 16'($urandom());
            do_read({hi, 8'(a)}, n);
            for (int k = 0; k < n; k++)
                check("rnd_rd", rx[k], model_read(a + k));
        end
        do_cmd(8'h02, 5);
        foreach (rx[k]) check("prog_ignored_miso", rx[k], 8'h00);
`endif

        // CS_n raised mid-address, then a clean ID read.
        cs_low();
        put(8'h03);
        put(8'h00);
        xfer(8'h00, 4, d);
        cs_high();
        do_cmd(8'h9F, 3);
        check("abort_id0", rx[0], 8'hEF);
        check("abort_id1", rx[1], 8'h40);
        check("abort_id2", rx[2], 8'h18);

        do_cmd(8'h06, 0);
        check("vcc_pre_wel", wel, 1);
        @(negedge CLKA);
        MEM_VCC = 1'b0;
        repeat (10) @(negedge CLKA);
        check("vcc_wel", wel, 0);
        check("vcc_miso", SPI_MISO, 0);
        check("vcc_cmd_code", cmd_code, 8'h00);
        MEM_VCC = 1'b1;
        repeat (4) @(negedge CLKA);
        do_cmd(8'h05, 1);
        check("vcc_st", rx[0], 8'h00);

        // Async reset in the middle of a read.
        do_cmd(8'h06, 0);
        cs_low();
        put(8'h03);
        put(8'h00);
        put(8'h00);
        put(8'h5A);
        get_bytes(1);
        xfer(8'h00, 3, d);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_miso", SPI_MISO, 0);
        check("mid_rst_cmd_code", cmd_code, 8'h00);
        check("mid_rst_wel", wel, 0);
        @(negedge CLKA);
        rst_n = 1'b1;
        repeat (10) @(negedge CLKA);
        SPI_CS_n = 1'b1;
        repeat (8) @(negedge CLKA);
        do_cmd(8'h9F, 3);
        check("post_rst_id0", rx[0], 8'hEF);
        check("post_rst_id1", rx[1], 8'h40);
        check("post_rst_id2", rx[2], 8'h18);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
